// File: rtl/name_entry_ctrl.sv
// Name-entry front end: turns button edges into a three-letter name and cursor
// position, then hands the finished name to the score store via valid/ready.
module name_entry_ctrl #(
  parameter int STRING_SIZE  = 15,
  parameter int CHAR_MAX     = 25,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_select,
  output logic [1:0]             input_pos,
  output logic [STRING_SIZE-1:0] player_name,
  output logic                   active,
  output logic                   commit_valid,
  input  logic                   commit_ready,
  output logic [STRING_SIZE-1:0] commit_name
);

  localparam int CW = STRING_SIZE / 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EDIT    = 2'd1,
    S_CONFIRM = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_UP   = 2'd1,
    R_DN   = 2'd2
  } rdir_t;

  state_t                 r_state, w_state_nx;
  logic [1:0]             r_pos, w_pos_nx;
  logic [STRING_SIZE-1:0] r_name, w_name_nx;
  logic [STRING_SIZE-1:0] r_cname, w_cname_nx;
  logic                   r_cvalid, w_cvalid_nx;
  logic                   r_active;
  logic                   r_start_q, r_up_q, r_dn_q, r_left_q, r_right_q, r_sel_q;
  rdir_t                  r_rpt_dir, w_rpt_start;
  logic [CNT_W-1:0]       r_rpt_cnt;
  logic                   r_rpt_rate;
  logic                   w_restart;
  logic                   w_rpt_held;
  logic [CNT_W-1:0]       w_rpt_lim;
  logic                   w_rpt_fire;
  logic                   w_start_e, w_up_e, w_dn_e, w_left_e, w_right_e, w_sel_e;

  function automatic logic [CW-1:0] char_step(input logic [CW-1:0] c, input logic up);
    logic [CW-1:0] r;
    if (up) begin
      if (c >= CW'(CHAR_MAX)) r = {CW{1'b0}};
      else                    r = c + CW'(1);
    end else begin
      if ((c == {CW{1'b0}}) || (c > CW'(CHAR_MAX))) r = CW'(CHAR_MAX);
      else                                          r = c - CW'(1);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] get_char(input logic [STRING_SIZE-1:0] n, input logic [1:0] p);
    logic [CW-1:0] r;
    case (p)
      2'd0:    r = n[STRING_SIZE-1 -: CW];
      2'd1:    r = n[STRING_SIZE-1-CW -: CW];
      2'd2:    r = n[CW-1:0];
      default: r = {CW{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [STRING_SIZE-1:0] step_name(input logic [STRING_SIZE-1:0] n,
                                                       input logic [1:0] p, input logic up);
    logic [STRING_SIZE-1:0] r;
    logic [CW-1:0]          c;
    r = n;
    c = char_step(get_char(n, p), up);
    case (p)
      2'd0:    r[STRING_SIZE-1 -: CW]    = c;
      2'd1:    r[STRING_SIZE-1-CW -: CW] = c;
      2'd2:    r[CW-1:0]                 = c;
      default: r = n;
    endcase
    return r;
  endfunction

  assign w_start_e = start      & ~r_start_q;
  assign w_up_e    = btn_up     & ~r_up_q;
  assign w_dn_e    = btn_down   & ~r_dn_q;
  assign w_left_e  = btn_left   & ~r_left_q;
  assign w_right_e = btn_right  & ~r_right_q;
  assign w_sel_e   = btn_select & ~r_sel_q;

  // Auto-repeat fires when the tracked button is still held and its interval has elapsed
  always_comb begin
    w_rpt_held = 1'b0;
    case (r_rpt_dir)
      R_UP:    w_rpt_held = btn_up;
      R_DN:    w_rpt_held = btn_down;
      default: w_rpt_held = 1'b0;
    endcase
    if (r_rpt_rate) w_rpt_lim = CNT_W'(REPEAT_RATE - 1);
    else            w_rpt_lim = CNT_W'(REPEAT_DELAY - 1);
    w_rpt_fire = (r_state == S_EDIT) && w_rpt_held && (r_rpt_cnt == w_rpt_lim);
  end

  // Next-state: one action per cycle, start > select > right > left > up > down > repeat
  always_comb begin
    w_state_nx  = r_state;
    w_pos_nx    = r_pos;
    w_name_nx   = r_name;
    w_cname_nx  = r_cname;
    w_cvalid_nx = r_cvalid;
    w_restart   = 1'b0;
    w_rpt_start = R_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_start_e) begin
          w_state_nx = S_EDIT;
          w_pos_nx   = 2'd0;
          w_name_nx  = {STRING_SIZE{1'b0}};
          w_restart  = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_EDIT: begin
        if (w_start_e) begin
          w_pos_nx  = 2'd0;
          w_name_nx = {STRING_SIZE{1'b0}};
          w_restart = 1'b1;
        end else if (w_sel_e || w_right_e) begin
          if (r_pos >= 2'd2) begin
            w_state_nx = S_CONFIRM;
            w_pos_nx   = 2'd3;
          end else begin
            w_pos_nx = r_pos + 2'd1;
          end
        end else if (w_left_e) begin
          if (r_pos != 2'd0) w_pos_nx = r_pos - 2'd1;
          else               w_pos_nx = 2'd0;
        end else if (w_up_e) begin
          w_name_nx = step_name(r_name, r_pos, 1'b1);
          if (r_rpt_dir == R_NONE) w_rpt_start = R_UP;
          else                     w_rpt_start = R_NONE;
        end else if (w_dn_e) begin
          w_name_nx = step_name(r_name, r_pos, 1'b0);
          if (r_rpt_dir == R_NONE) w_rpt_start = R_DN;
          else                     w_rpt_start = R_NONE;
        end else if (w_rpt_fire) begin
          w_name_nx = step_name(r_name, r_pos, r_rpt_dir == R_UP);
        end else begin
          w_state_nx = S_EDIT;
        end
      end
      S_CONFIRM: begin
        if (w_start_e) begin
          w_state_nx = S_EDIT;
          w_pos_nx   = 2'd0;
          w_name_nx  = {STRING_SIZE{1'b0}};
          w_restart  = 1'b1;
        end else if (w_sel_e) begin
          w_state_nx  = S_COMMIT;
          w_cname_nx  = r_name;
          w_cvalid_nx = 1'b1;
        end else if (w_left_e) begin
          w_state_nx = S_EDIT;
          w_pos_nx   = 2'd2;
        end else begin
          w_state_nx = S_CONFIRM;
        end
      end
      S_COMMIT: begin
        if (r_cvalid && commit_ready) begin
          w_state_nx  = S_IDLE;
          w_cvalid_nx = 1'b0;
          w_pos_nx    = 2'd0;
        end else begin
          w_state_nx = S_COMMIT;
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_pos_nx    = 2'd0;
        w_cvalid_nx = 1'b0;
      end
    endcase
  end

  // Main state, outputs and input-history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pos     <= 2'd0;
      r_name    <= {STRING_SIZE{1'b0}};
      r_cname   <= {STRING_SIZE{1'b0}};
      r_cvalid  <= 1'b0;
      r_active  <= 1'b0;
      r_start_q <= 1'b0;
      r_up_q    <= 1'b0;
      r_dn_q    <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
      r_sel_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pos     <= w_pos_nx;
      r_name    <= w_name_nx;
      r_cname   <= w_cname_nx;
      r_cvalid  <= w_cvalid_nx;
      r_active  <= (w_state_nx == S_EDIT) || (w_state_nx == S_CONFIRM);
      r_start_q <= start;
      r_up_q    <= btn_up;
      r_dn_q    <= btn_down;
      r_left_q  <= btn_left;
      r_right_q <= btn_right;
      r_sel_q   <= btn_select;
    end
  end

  // Repeat tracker: a cursor move, restart or leaving EDIT drops it; a fresh edge is needed to resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_dir  <= R_NONE;
      r_rpt_cnt  <= {CNT_W{1'b0}};
      r_rpt_rate <= 1'b0;
    end else if ((w_state_nx != S_EDIT) || (w_pos_nx != r_pos) || w_restart) begin
      r_rpt_dir  <= R_NONE;
      r_rpt_cnt  <= {CNT_W{1'b0}};
      r_rpt_rate <= 1'b0;
    end else if (w_rpt_start != R_NONE) begin
      r_rpt_dir  <= w_rpt_start;
      r_rpt_cnt  <= {CNT_W{1'b0}};
      r_rpt_rate <= 1'b0;
    end else if ((r_rpt_dir != R_NONE) && !w_rpt_held) begin
      r_rpt_dir  <= R_NONE;
      r_rpt_cnt  <= {CNT_W{1'b0}};
      r_rpt_rate <= 1'b0;
    end else if (r_rpt_dir != R_NONE) begin
      if (r_rpt_cnt == w_rpt_lim) begin
        r_rpt_cnt  <= {CNT_W{1'b0}};
        r_rpt_rate <= 1'b1;
      end else begin
        r_rpt_cnt  <= r_rpt_cnt + CNT_W'(1);
      end
    end else begin
      r_rpt_cnt <= {CNT_W{1'b0}};
    end
  end

  assign input_pos    = r_pos;
  assign player_name  = r_name;
  assign active       = r_active;
  assign commit_valid = r_cvalid;
  assign commit_name  = r_cname;

endmodule

// File: doc/name_entry_ctrl.md
Name: name_entry_ctrl

Overview:
Sequential front end for the scoreboard screen. Turns button levels into a three-letter player name and a cursor position. Drives input_pos and player_name straight into the scoreboard pixel renderer, which shows the highlight box and letters. On confirm it hands the finished name to the score store through a valid/ready handshake.

Parameters:
STRING_SIZE, 15 (from constants.svh), name width: 3 chars x 5 bits.
CHAR_MAX, 25, highest letter code: 0=A ... 25=Z; the renderer adds the font offset.
REPEAT_DELAY, 50_000_000, cycles an up/down button must be held before the first auto-repeat step.
REPEAT_RATE, 10_000_000, cycles between later auto-repeat steps.
CNT_W, 26, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge opens name entry
btn_up  in  1  debounced, synchronous level
btn_down  in  1  debounced, synchronous level
btn_left  in  1  debounced, synchronous level
btn_right  in  1  debounced, synchronous level
btn_select  in  1  debounced, synchronous level
input_pos  out  2  cursor position to the renderer: 0..2 = letter, 3 = whole-name confirm box
player_name  out  STRING_SIZE  {ch0,ch1,ch2}; ch0 is [14:10], ch2 is [4:0]
active  out  1  high in EDIT and CONFIRM
commit_valid  out  1  finished name available
commit_ready  in  1  consumer accepts
commit_name  out  STRING_SIZE  name snapshot, stable while commit_valid is high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; input_pos=0, player_name=0, active=0, commit_valid=0, commit_name=0.
  - All edge registers and repeat counters cleared.
  - Reset mid-entry or mid-commit abandons the name; no commit is emitted.
- Edge detection: every input is registered each cycle. An action fires on a 0->1 transition. All outputs are registered, so the effect appears on the clock edge after the first high sample (1-cycle latency).
- One action per cycle. Priority: start > select > right > left > up > down. Lower-priority edges in the same cycle are dropped, not queued.
- IDLE:
  - active=0; player_name keeps its last value.
  - start edge -> EDIT, input_pos=0, player_name=0 ("AAA").
- EDIT (input_pos 0..2):
  - right or select: input_pos+1. From pos 2, go to CONFIRM with input_pos=3.
  - left: input_pos-1, saturating at 0.
  - up: ch[input_pos]+1, wrapping 25->0.
  - down: ch[input_pos]-1, wrapping 0->25.
  - Codes 26..31 are never produced.
- Auto-repeat (EDIT only, up/down):
  - While the button stays high after its edge, the counter counts from 0.
  - At REPEAT_DELAY the same step is applied again. After that, one step every REPEAT_RATE cycles.
  - The counter clears on button release, on any input_pos change, or on leaving EDIT.
  - If both up and down are held, only the repeat of the button whose edge came first continues.
- CONFIRM (input_pos=3):
  - left -> EDIT with input_pos=2.
  - right, up, down ignored.
  - select -> COMMIT. commit_name is loaded with player_name on that edge; commit_valid=1 from the next cycle.
- COMMIT:
  - active=0, input_pos held at 3; all buttons and start ignored.
  - Transfer occurs in a cycle where commit_valid && commit_ready. The next cycle: commit_valid=0, state=IDLE, input_pos=0.
  - If commit_ready is already high in the first valid cycle, valid lasts exactly 1 cycle.
  - commit_name and player_name stay constant while valid is high.
- start edge in EDIT/CONFIRM: restart, name cleared to "AAA", input_pos=0.

Test Plan:
- Reset, then start pulse -> next cycle active=1, input_pos=0, player_name=15'h0000.
- In EDIT pos0, down pulse -> ch0=25 (player_name[14:10]=5'd25). Then up pulse -> ch0=0. At pos2, up x3 -> player_name[4:0]=3.
- left at pos0 -> stays 0. right x3 -> input_pos 1, 2, 3. In CONFIRM, right -> stays 3; left -> 2.
- btn_up held REPEAT_DELAY+2*REPEAT_RATE+1 cycles (params 8/3) at pos1 -> ch1 increments exactly 4 times (edge, delay, 2 repeats). Release -> counter clears.
- Name "CAT" (2,0,19), select in CONFIRM with commit_ready=0 for 5 cycles -> commit_valid high 5+ cycles, commit_name=15'h0813 stable. Raise ready -> valid drops next cycle, state IDLE.
- right and up edges in same cycle -> only input_pos changes. Assert rst_n=0 mid-COMMIT -> commit_valid=0 immediately, with no handshake.
